// File: rtl/feature_threshold_pkg.sv
// Shared types for the feature-threshold fetch slice.
// Threshold, address, count types plus FSM and buffer entry.
package feature_threshold_pkg;
  localparam int W_DATA = 13;
  localparam int W_ADDR = 12;
  localparam int W_CNT  = 8;

  typedef logic signed [W_DATA-1:0] thr_t;
  typedef logic [W_ADDR-1:0] rom_addr_t;
  typedef logic [W_CNT-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic last;
    thr_t data;
  } thr_entry_t;
endpackage

// File: rtl/feature_threshold_fetch_if.sv
// Command and threshold-stream handshakes of the fetch block.
// master: the fetch block side; slave: controller/comparator side.
interface feature_threshold_fetch_if;
  import feature_threshold_pkg::*;

  logic      start_valid;
  logic      start_ready;
  rom_addr_t start_addr;
  cnt_t      start_count;
  logic      thr_valid;
  logic      thr_ready;
  thr_t      thr_data;
  logic      thr_last;

  modport master (
    input  start_valid, start_addr,
    input  start_count, thr_ready,
    output start_ready, thr_valid,
    output thr_data, thr_last
  );

  modport slave (
    output start_valid, start_addr,
    output start_count, thr_ready,
    input  start_ready, thr_valid,
    input  thr_data, thr_last
  );
endinterface

// File: rtl/threshold_skid_fifo.sv
// Two-entry FIFO of {last, data} absorbing ROM read latency.
// Simultaneous push and pop leave occupancy unchanged.
module threshold_skid_fifo
  import feature_threshold_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  thr_entry_t din,
  output logic [1:0] occ,
  output thr_entry_t head
);

  thr_entry_t mem [2];
  logic       wp;
  logic       rp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rp];

endmodule

// File: rtl/feature_threshold_fetch.sv
// Read-side initiator for the feature-threshold ROM.
// Issues credit-limited reads and streams thresholds out.
module feature_threshold_fetch
  import feature_threshold_pkg::*;
(
  input  logic clk,
  input  logic rst,
  feature_threshold_fetch_if.master bus,
  output logic      rom_en,
  output rom_addr_t rom_addr,
  input  thr_t      rom_data,
  output logic      busy,
  output logic      done
);

  fetch_state_t state;
  fetch_state_t state_nx;
  rom_addr_t    nxt_addr;
  cnt_t         rem;
  logic         infl;
  logic         infl_last;
  logic [1:0]   occ;
  thr_entry_t   head;
  thr_entry_t   din;
  logic         accept;
  logic         pop;
  logic         pop_last;
  logic         issue;
  logic         rem_one;
  logic [2:0]   held;

  assign accept   = bus.start_valid &&
                    bus.start_ready;
  assign pop      = bus.thr_valid && bus.thr_ready;
  assign pop_last = pop && head.last;
  assign rem_one  = (rem == cnt_t'(1));

  // Buffered plus in-flight words, net of this cycle's pop, must stay below 2
  assign held  = {1'b0, occ} + {2'b0, infl};
  assign issue = (state == FETCH) &&
                 (held < 3'd2 + {2'b0, pop});

  assign rom_en   = issue;
  assign rom_addr = nxt_addr;

  assign bus.start_ready = (state == IDLE);
  assign bus.thr_valid   = (occ != 2'd0);
  assign bus.thr_data    = head.data;
  assign bus.thr_last    = head.last;
  assign busy            = (state != IDLE);

  assign din.last = infl_last;
  assign din.data = rom_data;

  threshold_skid_fifo u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (infl),
    .pop  (pop),
    .din  (din),
    .occ  (occ),
    .head (head)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (accept && bus.start_count != '0)
          state_nx = FETCH;
      FETCH:
        if (issue && rem_one) state_nx = DRAIN;
      DRAIN:
        if (pop_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      nxt_addr  <= '0;
      rem       <= '0;
      infl      <= 1'b0;
      infl_last <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      infl      <= issue;
      infl_last <= issue && rem_one;
      done      <= (accept &&
                    bus.start_count == '0) ||
                   (state == DRAIN && pop_last);
      if (accept) begin
        nxt_addr <= bus.start_addr;
        rem      <= bus.start_count;
      end else if (issue) begin
        nxt_addr <= nxt_addr + 1'b1;
        rem      <= rem - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_feature_threshold_fetch.sv
// Self-checking bench for feature_threshold_fetch.
// ROM model plus address-range reference for the stream.
module tb_feature_threshold_fetch;
  import feature_threshold_pkg::*;

  logic      clk = 1'b0;
  logic      rst = 1'b0;
  logic      rom_en;
  rom_addr_t rom_addr;
  thr_t      rom_data;
  logic      busy;
  logic      done;
  thr_t      rom_mem [4096];
  int        checks = 0;
  int        errors = 0;

  always #5 clk = ~clk;

  feature_threshold_fetch_if bus ();

  feature_threshold_fetch dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .busy     (busy),
    .done     (done)
  );

  always @(posedge clk or negedge rst)
    if (!rst) rom_data <= '0;
    else if (rom_en) rom_data <= rom_mem[rom_addr];

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks += 8;
    if (bus.start_ready !== 1'b1) begin errors++; $display("FAIL reset start_ready got %b want 1", bus.start_ready); end
    if (rom_en !== 1'b0) begin errors++; $display("FAIL reset rom_en got %b want 0", rom_en); end
    if (rom_addr !== 12'h000) begin errors++; $display("FAIL reset rom_addr got %h want 000", rom_addr); end
    if (bus.thr_valid !== 1'b0) begin errors++; $display("FAIL reset thr_valid got %b want 0", bus.thr_valid); end
    if (bus.thr_data !== 13'h0) begin errors++; $display("FAIL reset thr_data got %h want 0", bus.thr_data); end
    if (bus.thr_last !== 1'b0) begin errors++; $display("FAIL reset thr_last got %b want 0", bus.thr_last); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset done got %b want 0", done); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Full-rate stream: reads in cycles 1..n, data 3..n+2, done n+3
  task automatic test_stream(input string tag,
                             input rom_addr_t a,
                             input cnt_t n);
    rom_addr_t ea;
    rom_addr_t ix;
    int nn;
    bit ee, ev, el, ed, eb;
    nn = int'(n);
    @(negedge clk);
    bus.start_valid = 1'b1;
    bus.start_addr  = a;
    bus.start_count = n;
    bus.thr_ready   = 1'b1;
    #1;
    checks++;
    if (bus.start_ready !== 1'b1) begin errors++; $display("FAIL %s start_ready got %b want 1", tag, bus.start_ready); end
    for (int c = 1; c <= nn + 3; c++) begin
      @(negedge clk);
      bus.start_valid = 1'b0;
      #1;
      ee = (c <= nn);
      ev = (c >= 3) && (c <= nn + 2);
      el = (c == nn + 2);
      ed = (c == nn + 3);
      eb = (c <= nn + 2);
      ea = a + rom_addr_t'(c - 1);
      ix = a + rom_addr_t'(c - 3);
      checks += 4;
      if (rom_en !== ee) begin errors++; $display("FAIL %s c%0d rom_en got %b want %b", tag, c, rom_en, ee); end
      if (bus.thr_valid !== ev) begin errors++; $display("FAIL %s c%0d thr_valid got %b want %b", tag, c, bus.thr_valid, ev); end
      if (done !== ed) begin errors++; $display("FAIL %s c%0d done got %b want %b", tag, c, done, ed); end
      if (busy !== eb) begin errors++; $display("FAIL %s c%0d busy got %b want %b", tag, c, busy, eb); end
      if (ee) begin
        checks++;
        if (rom_addr !== ea) begin errors++; $display("FAIL %s c%0d rom_addr got %h want %h", tag, c, rom_addr, ea); end
      end
      if (ev) begin
        checks += 2;
        if (bus.thr_data !== rom_mem[ix]) begin errors++; $display("FAIL %s c%0d thr_data got %h want %h", tag, c, bus.thr_data, rom_mem[ix]); end
        if (bus.thr_last !== el) begin errors++; $display("FAIL %s c%0d thr_last got %b want %b", tag, c, bus.thr_last, el); end
      end
    end
  endtask

  task automatic test_zero();
    @(negedge clk);
    bus.start_valid = 1'b1;
    bus.start_addr  = rom_addr_t'($urandom);
    bus.start_count = '0;
    #1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      bus.start_valid = 1'b0;
      #1;
      checks += 4;
      if (done !== (c == 1)) begin errors++; $display("FAIL zero c%0d done got %b want %b", c, done, c == 1); end
      if (rom_en !== 1'b0) begin errors++; $display("FAIL zero c%0d rom_en got %b want 0", c, rom_en); end
      if (bus.thr_valid !== 1'b0) begin errors++; $display("FAIL zero c%0d thr_valid got %b want 0", c, bus.thr_valid); end
      if (bus.start_ready !== 1'b1) begin errors++; $display("FAIL zero c%0d start_ready got %b want 1", c, bus.start_ready); end
    end
  endtask

  task automatic test_backpressure();
    rom_addr_t a;
    rom_addr_t ix;
    thr_t held;
    int issued, popped, dones, low, cyc;
    bit seen;
    a = rom_addr_t'($urandom);
    issued = 0; popped = 0; dones = 0;
    low = 0; seen = 0; cyc = 0;
    @(negedge clk);
    bus.start_valid = 1'b1;
    bus.start_addr  = a;
    bus.start_count = 8'd4;
    bus.thr_ready   = 1'b0;
    #1;
    while (dones == 0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      bus.start_valid = 1'b0;
      bus.thr_ready   = seen && (low >= 5);
      #1;
      if (rom_en) issued++;
      if (bus.thr_valid && !seen) begin
        seen = 1;
        held = bus.thr_data;
        checks++;
        if (held !== rom_mem[a]) begin errors++; $display("FAIL bp first got %h want %h", held, rom_mem[a]); end
      end
      if (bus.thr_valid && !bus.thr_ready) begin
        low++;
        checks++;
        if (bus.thr_data !== held) begin errors++; $display("FAIL bp hold got %h want %h", bus.thr_data, held); end
      end
      if (bus.thr_valid && bus.thr_ready) begin
        ix = a + rom_addr_t'(popped);
        checks += 2;
        if (bus.thr_data !== rom_mem[ix]) begin errors++; $display("FAIL bp data%0d got %h want %h", popped, bus.thr_data, rom_mem[ix]); end
        if (bus.thr_last !== (popped == 3)) begin errors++; $display("FAIL bp last%0d got %b want %b", popped, bus.thr_last, popped == 3); end
        popped++;
      end
      checks++;
      if (issued - popped > 2) begin errors++; $display("FAIL bp credit got %0d ahead want <=2", issued - popped); end
      if (done) dones++;
    end
    checks += 3;
    if (dones != 1) begin errors++; $display("FAIL bp done got %0d want 1", dones); end
    if (popped != 4) begin errors++; $display("FAIL bp pops got %0d want 4", popped); end
    if (issued != 4) begin errors++; $display("FAIL bp reads got %0d want 4", issued); end
  endtask

  task automatic test_busy_reset();
    @(negedge clk);
    bus.start_valid = 1'b1;
    bus.start_addr  = rom_addr_t'($urandom);
    bus.start_count = 8'd5;
    bus.thr_ready   = 1'b1;
    #1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      bus.start_addr  = 12'h7F0;
      bus.start_count = 8'd2;
      #1;
      checks++;
      if (bus.start_ready !== (c == 8)) begin errors++; $display("FAIL busy c%0d start_ready got %b want %b", c, bus.start_ready, c == 8); end
      if (c == 8) begin
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL busy done got %b want 1", done); end
      end
    end
    repeat (3) begin
      @(negedge clk);
      bus.start_valid = 1'b0;
    end
    #1;
    checks += 2;
    if (busy !== 1'b1) begin errors++; $display("FAIL rst pre busy got %b want 1", busy); end
    if (bus.thr_valid !== 1'b1) begin errors++; $display("FAIL rst pre thr_valid got %b want 1", bus.thr_valid); end
    rst = 1'b0;
    #1;
    checks += 6;
    if (bus.start_ready !== 1'b1) begin errors++; $display("FAIL rst start_ready got %b want 1", bus.start_ready); end
    if (rom_en !== 1'b0) begin errors++; $display("FAIL rst rom_en got %b want 0", rom_en); end
    if (bus.thr_valid !== 1'b0) begin errors++; $display("FAIL rst thr_valid got %b want 0", bus.thr_valid); end
    if (bus.thr_data !== 13'h0) begin errors++; $display("FAIL rst thr_data got %h want 0", bus.thr_data); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst busy got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL rst done got %b want 0", done); end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      checks += 2;
      if (bus.thr_valid !== 1'b0) begin errors++; $display("FAIL rst post thr_valid got %b want 0", bus.thr_valid); end
      if (done !== 1'b0) begin errors++; $display("FAIL rst post done got %b want 0", done); end
    end
  endtask

  task automatic test_random_stress();
    thr_t exp_d [$];
    bit   exp_l [$];
    int   sent, acc, dones, lasts, want_lasts, cyc;
    bit   clr;
    rom_addr_t a;
    cnt_t n;
    thr_t ed;
    bit el;
    sent = 0; acc = 0; dones = 0;
    lasts = 0; want_lasts = 0; cyc = 0; clr = 0;
    while ((acc < 60 || exp_d.size() > 0 || dones < acc) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (clr) begin bus.start_valid = 1'b0; clr = 0; end
      if (!bus.start_valid && sent < 60 && $urandom_range(0, 3) == 0) begin
        a = ($urandom_range(0, 3) == 0) ? 12'hFF0 + rom_addr_t'($urandom_range(0, 15)) : rom_addr_t'($urandom);
        n = ($urandom_range(0, 9) == 0) ? 8'd0 : cnt_t'($urandom_range(1, 12));
        bus.start_valid = 1'b1;
        bus.start_addr  = a;
        bus.start_count = n;
        sent++;
      end
      bus.thr_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (bus.start_valid && bus.start_ready) begin
        for (int i = 0; i < int'(bus.start_count); i++) begin
          exp_d.push_back(rom_mem[bus.start_addr + rom_addr_t'(i)]);
          exp_l.push_back(i == int'(bus.start_count) - 1);
        end
        if (bus.start_count != 0) want_lasts++;
        acc++;
        clr = 1;
      end
      if (bus.thr_valid && bus.thr_ready) begin
        checks++;
        if (exp_d.size() == 0) begin
          errors++;
          $display("FAIL stress extra got %h want none", bus.thr_data);
        end else begin
          ed = exp_d.pop_front();
          el = exp_l.pop_front();
          checks++;
          if (bus.thr_data !== ed) begin errors++; $display("FAIL stress data got %h want %h", bus.thr_data, ed); end
          if (bus.thr_last !== el) begin errors++; $display("FAIL stress last got %b want %b", bus.thr_last, el); end
        end
        if (bus.thr_last) lasts++;
      end
      if (done) dones++;
    end
    bus.start_valid = 1'b0;
    checks += 5;
    if (cyc >= 20000) begin errors++; $display("FAIL stress timeout got %0d cycles want <20000", cyc); end
    if (acc != 60) begin errors++; $display("FAIL stress accepted got %0d want 60", acc); end
    if (dones != acc) begin errors++; $display("FAIL stress dones got %0d want %0d", dones, acc); end
    if (lasts != want_lasts) begin errors++; $display("FAIL stress lasts got %0d want %0d", lasts, want_lasts); end
    if (exp_d.size() != 0) begin errors++; $display("FAIL stress left got %0d want 0", exp_d.size()); end
  endtask

  initial begin
    bus.start_valid = 1'b0;
    bus.start_addr  = '0;
    bus.start_count = '0;
    bus.thr_ready   = 1'b0;
    for (int i = 0; i < 4096; i++)
      rom_mem[i] = thr_t'($urandom);
    rom_mem[0] = 13'h1F7F;
    rom_mem[1] = 13'h0032;
    rom_mem[2] = 13'h0059;
    test_reset();
    test_stream("basic", 12'h000, 8'd3);
    test_zero();
    test_backpressure();
    test_stream("wrap", 12'hFFE, 8'd3);
    test_busy_reset();
    test_stream("postrst", rom_addr_t'($urandom), 8'd3);
    test_random_stress();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
